laser500_mmu: RTL and testbench
===============================

LASER500_MMU -- requirements
Module: laser500_mmu

Interface
REQ-001 clk  in  1  system clock; all CPU bus inputs are synchronous to it.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 cpu_addr  in  16  Z80 address bus.
REQ-004 cpu_dout  in  8  Z80 write data.
REQ-005 cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n  in  1 each  Z80 strobes, active low.
REQ-006 kbd_cols  in  8  keyboard column data for the selected rows, active low.
REQ-007 cas_in  in  1  cassette input level.
REQ-008 ram_dout  in  8  read data from the sdram controller.
REQ-009 ram_addr  out  25  sdram byte address.
REQ-010 ram_din  out  8  sdram write data; equals cpu_dout.
REQ-011 ram_we  out  1  sdram write request, active high.
REQ-012 ram_oe  out  1  sdram read request, active high.
REQ-013 cpu_din  out  8  registered read data to the CPU.
REQ-014 kbd_rows  out  8  keyboard row select, active low.
REQ-015 io_latch  out  8  system latch: bit0 speaker A, bits 1-2 cassette out, bit3 video mode, bit5 speaker B.
REQ-016 vpage  out  1  video page select for the video generator.

Function
REQ-017 Four page registers PR0-PR3, 4 bits each, map CPU pages 0000-3FFF, 4000-7FFF, 8000-BFFF and C000-FFFF.
REQ-018 The selected page is p = cpu_addr[15:14]; the effective bank is b = PRp.
REQ-019 ram_addr = {7'b0, b, cpu_addr[13:0]}; the output is combinational from cpu_addr and the page registers.
REQ-020 Bank class: 0-1 ROM, 2 I/O space, 3-15 RAM.
REQ-021 ram_oe = memory read (mreq_n=0, rd_n=0) to a ROM or RAM bank.
REQ-022 ram_we = memory write (mreq_n=0, wr_n=0) to a RAM bank only; writes to ROM banks are discarded with no side effect.
REQ-023 The I/O bank is memory-mapped. A read at offset 0x2800-0x2FFF drives kbd_rows = cpu_addr[7:0] and returns {cas_in, kbd_cols[6:0]}.
REQ-024 Any other read in the I/O bank returns 0xFF.
REQ-025 A write anywhere in the I/O bank loads io_latch with cpu_dout.
REQ-026 kbd_rows = 0xFF whenever no keyboard read is in progress.
REQ-027 I/O ports (iorq_n=0, m1_n=1) decode cpu_addr[7:0]: 0x40-0x43 write PR0-PR3 from cpu_dout[3:0]; 0x44 writes vpage from cpu_dout[0].
REQ-028 Reads of ports 0x40-0x43 return {4'h0, PRn}. Reads of 0x44 return {7'h0, vpage}. Reads of any other port return 0xFF.
REQ-029 Register and latch writes (page registers, vpage, io_latch) occur exactly once per bus cycle, on the first clk edge where the write strobe condition is true. The condition is detected by comparing with its value registered on the previous clk. Holding wr_n low for N clocks still produces one update.
REQ-030 Interrupt acknowledge (iorq_n=0, m1_n=0) returns 0xFF on cpu_din and performs no register access.
REQ-031 cpu_din is registered: the value selected on edge k is visible after edge k. Latency is 1 clk. It holds its last value when no read is active.
REQ-032 mreq_n and iorq_n low together is illegal: neither access takes effect, and ram_we and ram_oe are 0.
REQ-033 A page register write that changes the page currently being addressed affects ram_addr from the clock after the write; no in-flight memory strobe is active during an I/O cycle.

Reset
REQ-034 While reset_n=0, asynchronously set PR0..PR3 = 0,1,2,3, io_latch=0x00, vpage=0, cpu_din=0xFF, and clear the edge-detect registers.
REQ-035 During reset, ram_we=0, ram_oe=0 and kbd_rows=0xFF regardless of bus inputs.
REQ-036 Reset asserted mid-cycle aborts that cycle. A strobe still low at release is not treated as a new edge: the edge registers release as "active" only if the strobe is held.

Verification
REQ-037 Reset, then memory read of 0x4123 → ram_addr=0x0004123, ram_oe=1, cpu_din=ram_dout one clk later.
REQ-038 OUT (0x43),0x07, then write 0xA5 to 0xC010 → PR3=7, ram_addr=0x001C010, ram_we=1, ram_din=0xA5.
REQ-039 Write 0x55 to 0x0100 (ROM bank 0) → ram_we stays 0; a subsequent read still returns the ROM data.
REQ-040 kbd_cols=0x7E, cas_in=1, memory read of 0xA8FE → kbd_rows=0xFE, cpu_din=0xFE; after the cycle kbd_rows=0xFF.
REQ-041 Write 0x09 to 0x8800 with wr_n held low for 5 clocks → io_latch=0x09, updated exactly once; assert reset_n=0 mid-hold → io_latch=0x00 immediately.
REQ-042 IRQ acknowledge (iorq_n=0, m1_n=0) with cpu_addr[7:0]=0x40 → cpu_din=0xFF and PR0 unchanged.

Source files
------------

// File: rtl/laser500_mmu.sv
// Laser 500 memory mapper: four 16K page registers, ROM/RAM/IO bank decode,
// memory-mapped keyboard and system latch, I/O-port page and video control.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   cpu_addr/dout/strobes   Z80 bus (strobes active low)
//   kbd_cols, cas_in        keyboard columns (active low), cassette level
//   ram_dout                sdram read data
//   ram_addr/din/we/oe      sdram request (combinational from the bus)
//   cpu_din                 registered read data to the CPU
//   kbd_rows                keyboard row select (active low)
//   io_latch, vpage         system latch and video page select

module laser500_mmu (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_m1_n,
  input  logic [7:0]  kbd_cols,
  input  logic        cas_in,
  input  logic [7:0]  ram_dout,
  output logic [24:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  output logic        ram_oe,
  output logic [7:0]  cpu_din,
  output logic [7:0]  kbd_rows,
  output logic [7:0]  io_latch,
  output logic        vpage
);

  logic [3:0] pr [4];
  logic [3:0] bank;
  logic [7:0] port;
  logic       is_io;
  logic       is_ram;
  logic       kbd_hit;
  logic       mem_rd;
  logic       mem_wr;
  logic       io_rd;
  logic       io_wr;
  logic       int_ack;
  logic       rd_act;
  logic       wr_act;
  logic       wr_q;
  logic       armed;
  logic       wr_fire;
  logic       port_pr;
  logic       port_vp;
  logic [7:0] rd_data;
  logic       unused_ok;

  assign unused_ok = kbd_cols[7];

  assign bank   = pr[cpu_addr[15:14]];
  assign port   = cpu_addr[7:0];
  assign is_io  = bank == 4'd2;
  assign is_ram = bank >= 4'd3;
  // keyboard window is offset 0x2800-0x2FFF of the I/O bank
  assign kbd_hit = is_io && (cpu_addr[13:11] == 3'b101);

  // mreq and iorq together is illegal, so each decode requires the other high
  assign mem_rd  = !cpu_mreq_n && cpu_iorq_n && !cpu_rd_n;
  assign mem_wr  = !cpu_mreq_n && cpu_iorq_n && !cpu_wr_n;
  assign io_rd   = !cpu_iorq_n && cpu_mreq_n && cpu_m1_n && !cpu_rd_n;
  assign io_wr   = !cpu_iorq_n && cpu_mreq_n && cpu_m1_n && !cpu_wr_n;
  assign int_ack = !cpu_iorq_n && cpu_mreq_n && !cpu_m1_n;
  assign rd_act  = mem_rd || io_rd || int_ack;

  assign port_pr = port[7:2] == 6'b010000;
  assign port_vp = port == 8'h44;

  assign ram_addr = {7'b0, bank, cpu_addr[13:0]};
  assign ram_din  = cpu_dout;
  assign ram_oe   = reset_n && mem_rd && !is_io;
  assign ram_we   = reset_n && mem_wr && is_ram;
  assign kbd_rows = (reset_n && mem_rd && kbd_hit) ? port : 8'hFF;

  // armed stays low after reset until the write strobe has been seen
  // inactive, so a strobe held across reset release is not a new edge
  assign wr_act  = mem_wr || io_wr;
  assign wr_fire = wr_act && !wr_q && armed;

  always_comb begin
    rd_data = 8'hFF;
    unique case (1'b1)
      mem_rd: begin
        if (!is_io)
          rd_data = ram_dout;
        else if (kbd_hit)
          rd_data = {cas_in, kbd_cols[6:0]};
      end
      io_rd: begin
        if (port_pr)
          rd_data = {4'h0, pr[port[1:0]]};
        else if (port_vp)
          rd_data = {7'h0, vpage};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pr[0]    <= 4'd0;
      pr[1]    <= 4'd1;
      pr[2]    <= 4'd2;
      pr[3]    <= 4'd3;
      io_latch <= 8'h00;
      vpage    <= 1'b0;
      cpu_din  <= 8'hFF;
      wr_q     <= 1'b0;
      armed    <= 1'b0;
    end else begin
      wr_q <= wr_act;
      if (!wr_act)
        armed <= 1'b1;
      if (wr_fire) begin
        if (mem_wr && is_io)
          io_latch <= cpu_dout;
        if (io_wr) begin
          unique case (1'b1)
            port_pr: pr[port[1:0]] <= cpu_dout[3:0];
            port_vp: vpage <= cpu_dout[0];
            default: ;
          endcase
        end
      end
      if (rd_act)
        cpu_din <= rd_data;
    end
  end

endmodule

// File: tb/tb_laser500_mmu.sv
// Self-checking bench for laser500_mmu: directed scenarios plus a
// randomized bus mix checked against a page-table model.

module tb_laser500_mmu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_dout = 8'h0;
  logic        cpu_mreq_n = 1'b1;
  logic        cpu_iorq_n = 1'b1;
  logic        cpu_rd_n = 1'b1;
  logic        cpu_wr_n = 1'b1;
  logic        cpu_m1_n = 1'b1;
  logic [7:0]  kbd_cols = 8'hFF;
  logic        cas_in = 1'b0;
  logic [7:0]  ram_dout = 8'h00;
  logic [24:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic        ram_oe;
  logic [7:0]  cpu_din;
  logic [7:0]  kbd_rows;
  logic [7:0]  io_latch;
  logic        vpage;

  int checks = 0;
  int failures = 0;

  logic [3:0] m_pr [4];
  logic [7:0] m_latch;
  logic       m_vpage;

  laser500_mmu dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n),
    .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_m1_n(cpu_m1_n), .kbd_cols(kbd_cols),
    .cas_in(cas_in), .ram_dout(ram_dout),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_oe(ram_oe),
    .cpu_din(cpu_din), .kbd_rows(kbd_rows),
    .io_latch(io_latch), .vpage(vpage)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic model_reset();
    m_pr[0] = 4'd0;
    m_pr[1] = 4'd1;
    m_pr[2] = 4'd2;
    m_pr[3] = 4'd3;
    m_latch = 8'h00;
    m_vpage = 1'b0;
  endtask

  function automatic int bank_of(input logic [15:0] a);
    return int'(m_pr[int'(a) / 16384]);
  endfunction

  function automatic logic [24:0] exp_addr(input logic [15:0] a);
    return 25'(bank_of(a) * 16384 + int'(a) % 16384);
  endfunction

  function automatic logic is_kbd(input logic [15:0] a);
    int off;
    off = int'(a) % 16384;
    return bank_of(a) == 2 && off >= 'h2800 && off <= 'h2FFF;
  endfunction

  function automatic logic [7:0] exp_mem_rd(input logic [15:0] a);
    if (bank_of(a) != 2)
      return ram_dout;
    if (is_kbd(a))
      return {cas_in, kbd_cols[6:0]};
    return 8'hFF;
  endfunction

  function automatic logic [7:0] exp_io_rd(input logic [7:0] p);
    if (p >= 8'h40 && p <= 8'h43)
      return {4'h0, m_pr[int'(p) - 64]};
    if (p == 8'h44)
      return {7'h0, m_vpage};
    return 8'hFF;
  endfunction

  task automatic bus_idle();
    cpu_mreq_n = 1'b1;
    cpu_iorq_n = 1'b1;
    cpu_rd_n   = 1'b1;
    cpu_wr_n   = 1'b1;
    cpu_m1_n   = 1'b1;
  endtask

  // flags are active high; drives at the falling edge
  task automatic drive(input logic [15:0] a, input logic [7:0] d,
                       input bit mreq, input bit iorq,
                       input bit rd, input bit wr, input bit m1);
    @(negedge clk);
    cpu_addr   = a;
    cpu_dout   = d;
    cpu_mreq_n = !mreq;
    cpu_iorq_n = !iorq;
    cpu_rd_n   = !rd;
    cpu_wr_n   = !wr;
    cpu_m1_n   = !m1;
    #1;
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #1;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic io_write(input logic [7:0] p, input logic [7:0] d);
    drive({8'h00, p}, d, 0, 1, 0, 1, 0);
    end_cycle();
    if (p >= 8'h40 && p <= 8'h43)
      m_pr[int'(p) - 64] = d[3:0];
    else if (p == 8'h44)
      m_vpage = d[0];
  endtask

  task automatic test_reset();
    model_reset();
    cpu_addr = 16'hC000;
    cpu_mreq_n = 1'b0;
    cpu_rd_n = 1'b0;
    cpu_wr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_we got=%b exp=0", ram_we);
    end
    checks++;
    if (ram_oe !== 1'b0) begin
      failures++;
      $display("FAIL rst_oe got=%b exp=0", ram_oe);
    end
    checks++;
    if (ram_addr !== 25'h000C000) begin
      failures++;
      $display("FAIL rst_addr got=%h exp=000c000", ram_addr);
    end
    cpu_addr = 16'hA8FE;
    #1;
    checks++;
    if (kbd_rows !== 8'hFF) begin
      failures++;
      $display("FAIL rst_rows got=%h exp=ff", kbd_rows);
    end
    checks++;
    if ({io_latch, vpage, cpu_din} !== {8'h00, 1'b0, 8'hFF}) begin
      failures++;
      $display("FAIL rst_regs got=%h/%b/%h exp=00/0/ff",
               io_latch, vpage, cpu_din);
    end
    bus_idle();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mem_read();
    ram_dout = 8'h3C;
    drive(16'h4123, 8'h00, 1, 0, 1, 0, 0);
    checks++;
    if (ram_addr !== 25'h0004123 || ram_oe !== 1'b1 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL rd_req got=%h/%b/%b exp=0004123/1/0",
               ram_addr, ram_oe, ram_we);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cpu_din !== 8'h3C) begin
      failures++;
      $display("FAIL rd_data got=%h exp=3c", cpu_din);
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_page_write();
    io_write(8'h43, 8'h07);
    drive(16'h0043, 8'h00, 0, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    checks++;
    if (cpu_din !== 8'h07) begin
      failures++;
      $display("FAIL pr3_read got=%h exp=07", cpu_din);
    end
    @(negedge clk);
    bus_idle();
    drive(16'hC010, 8'hA5, 1, 0, 0, 1, 0);
    checks++;
    if (ram_addr !== 25'h001C010 || ram_we !== 1'b1 ||
        ram_din !== 8'hA5 || ram_oe !== 1'b0) begin
      failures++;
      $display("FAIL pr3_wr got=%h/%b/%h/%b exp=001c010/1/a5/0",
               ram_addr, ram_we, ram_din, ram_oe);
    end
    end_cycle();
  endtask

  task automatic test_rom_write();
    drive(16'h0100, 8'h55, 1, 0, 0, 1, 0);
    checks++;
    if (ram_we !== 1'b0) begin
      failures++;
      $display("FAIL rom_we got=%b exp=0", ram_we);
    end
    end_cycle();
    checks++;
    if (io_latch !== m_latch) begin
      failures++;
      $display("FAIL rom_latch got=%h exp=%h", io_latch, m_latch);
    end
    ram_dout = 8'h8F;
    drive(16'h0100, 8'h00, 1, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    checks++;
    if (cpu_din !== 8'h8F || ram_oe !== 1'b1) begin
      failures++;
      $display("FAIL rom_rd got=%h/%b exp=8f/1", cpu_din, ram_oe);
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_kbd();
    kbd_cols = 8'h7E;
    cas_in = 1'b1;
    drive(16'hA8FE, 8'h00, 1, 0, 1, 0, 0);
    checks++;
    if (kbd_rows !== 8'hFE || ram_oe !== 1'b0) begin
      failures++;
      $display("FAIL kbd_rows got=%h/%b exp=fe/0", kbd_rows, ram_oe);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cpu_din !== 8'hFE) begin
      failures++;
      $display("FAIL kbd_data got=%h exp=fe", cpu_din);
    end
    @(negedge clk);
    bus_idle();
    #1;
    checks++;
    if (kbd_rows !== 8'hFF) begin
      failures++;
      $display("FAIL kbd_idle got=%h exp=ff", kbd_rows);
    end
    drive(16'h8123, 8'h00, 1, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    checks++;
    if (cpu_din !== 8'hFF || kbd_rows !== 8'hFF) begin
      failures++;
      $display("FAIL io_other got=%h/%h exp=ff/ff", cpu_din, kbd_rows);
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_latch_hold();
    drive(16'h8800, 8'h09, 1, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    m_latch = 8'h09;
    checks++;
    if (io_latch !== 8'h09) begin
      failures++;
      $display("FAIL hold_first got=%h exp=09", io_latch);
    end
    cpu_dout = 8'h33;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (io_latch !== 8'h09) begin
        failures++;
        $display("FAIL hold_once got=%h exp=09", io_latch);
      end
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (io_latch !== 8'h00 || cpu_din !== 8'hFF) begin
      failures++;
      $display("FAIL hold_rst got=%h/%h exp=00/ff", io_latch, cpu_din);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (io_latch !== 8'h00) begin
      failures++;
      $display("FAIL rel_held got=%h exp=00", io_latch);
    end
    @(negedge clk);
    bus_idle();
    drive(16'h8800, 8'h5A, 1, 0, 0, 1, 0);
    end_cycle();
    m_latch = 8'h5A;
    checks++;
    if (io_latch !== 8'h5A) begin
      failures++;
      $display("FAIL rel_new got=%h exp=5a", io_latch);
    end
  endtask

  task automatic test_intack();
    io_write(8'h40, 8'h05);
    drive(16'h0040, 8'h00, 0, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    checks++;
    if (cpu_din !== 8'h05) begin
      failures++;
      $display("FAIL pr0_read got=%h exp=05", cpu_din);
    end
    @(negedge clk);
    bus_idle();
    drive(16'h0040, 8'h0C, 0, 1, 0, 0, 1);
    @(posedge clk);
    #1;
    checks++;
    if (cpu_din !== 8'hFF) begin
      failures++;
      $display("FAIL inta_data got=%h exp=ff", cpu_din);
    end
    @(negedge clk);
    bus_idle();
    drive(16'h0040, 8'h00, 0, 1, 1, 0, 0);
    checks++;
    if (ram_addr !== exp_addr(16'h0040)) begin
      failures++;
      $display("FAIL inta_map got=%h exp=%h", ram_addr, exp_addr(16'h0040));
    end
    @(posedge clk);
    #1;
    checks++;
    if (cpu_din !== 8'h05) begin
      failures++;
      $display("FAIL inta_pr0 got=%h exp=05", cpu_din);
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_illegal();
    drive(16'hC040, 8'h0B, 1, 1, 1, 1, 0);
    checks++;
    if (ram_we !== 1'b0 || ram_oe !== 1'b0) begin
      failures++;
      $display("FAIL ill_req got=%b/%b exp=0/0", ram_we, ram_oe);
    end
    end_cycle();
    drive(16'h0040, 8'h00, 0, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    checks++;
    if (cpu_din !== exp_io_rd(8'h40)) begin
      failures++;
      $display("FAIL ill_pr0 got=%h exp=%h", cpu_din, exp_io_rd(8'h40));
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  p;
    logic [7:0]  e;
    int          op;
    for (int i = 0; i < 120; i++) begin
      op = int'($urandom_range(0, 5));
      a = 16'($urandom);
      d = 8'($urandom);
      ram_dout = 8'($urandom);
      kbd_cols = 8'($urandom);
      cas_in = 1'($urandom);
      case (op)
        0: io_write(8'h40 + 8'($urandom_range(0, 3)), d);
        1: io_write(8'h44, d);
        2, 3: begin
          if ($urandom_range(0, 2) == 0)
            a = {a[15:14], 3'b101, a[10:0]};
          drive(a, 8'h00, 1, 0, 1, 0, 0);
          e = exp_mem_rd(a);
          checks++;
          if (ram_addr !== exp_addr(a) ||
              ram_oe !== (bank_of(a) != 2) ||
              kbd_rows !== (is_kbd(a) ? a[7:0] : 8'hFF)) begin
            failures++;
            $display("FAIL rnd_rd_req a=%h got=%h/%b/%h exp=%h/%b/%h",
                     a, ram_addr, ram_oe, kbd_rows, exp_addr(a),
                     bank_of(a) != 2, is_kbd(a) ? a[7:0] : 8'hFF);
          end
          @(posedge clk);
          #1;
          checks++;
          if (cpu_din !== e) begin
            failures++;
            $display("FAIL rnd_rd_data a=%h got=%h exp=%h", a, cpu_din, e);
          end
          @(negedge clk);
          bus_idle();
        end
        4: begin
          drive(a, d, 1, 0, 0, 1, 0);
          checks++;
          if (ram_addr !== exp_addr(a) || ram_we !== (bank_of(a) >= 3)) begin
            failures++;
            $display("FAIL rnd_wr_req a=%h got=%h/%b exp=%h/%b",
                     a, ram_addr, ram_we, exp_addr(a), bank_of(a) >= 3);
          end
          if (bank_of(a) == 2)
            m_latch = d;
          end_cycle();
          checks++;
          if (io_latch !== m_latch) begin
            failures++;
            $display("FAIL rnd_latch a=%h got=%h exp=%h", a, io_latch, m_latch);
          end
        end
        default: begin
          p = 8'h3E + 8'($urandom_range(0, 8));
          drive({a[15:8], p}, 8'h00, 0, 1, 1, 0, 0);
          @(posedge clk);
          #1;
          checks++;
          if (cpu_din !== exp_io_rd(p) || vpage !== m_vpage) begin
            failures++;
            $display("FAIL rnd_port p=%h got=%h/%b exp=%h/%b",
                     p, cpu_din, vpage, exp_io_rd(p), m_vpage);
          end
          @(negedge clk);
          bus_idle();
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_page_write();
    test_rom_write();
    test_kbd();
    test_latch_hold();
    test_intack();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
